// File: rtl/mult_pow_seq_if.sv
// Request/response bundle for mult_pow_seq: operand handshake in, result handshake out.
interface mult_pow_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EXP_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [EXP_W-1:0] k;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             overflow;

  modport master (
    output in_valid, a, b, k, out_ready,
    input  in_ready, out_valid, out, overflow
  );

  modport slave (
    input  in_valid, a, b, k, out_ready,
    output in_ready, out_valid, out, overflow
  );
endinterface

// File: rtl/mult_pow_seq.sv
// Iterative a * b^k (mod 2^WIDTH): one shift-add multiplier bit per cycle, k passes,
// sticky overflow when any pass product spills past WIDTH bits.
module mult_pow_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EXP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_pow_seq_if.slave      bus
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [PW-1:0]    prod;
  logic [IDX_W-1:0] bit_idx;
  logic [EXP_W-1:0] pass_cnt;
  logic             ovf;

  logic             accept;
  logic             last_bit;
  logic             last_pass;
  logic [PW-1:0]    term;
  logic [PW-1:0]    psum;
  logic             ovf_nxt;

  // Next-state decode plus the current-cycle partial sum
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    last_pass = 1'b0;
    term      = b_reg[bit_idx] ? ({{WIDTH{1'b0}}, acc} << bit_idx) : '0;
    psum      = prod + term;
    ovf_nxt   = ovf | (psum[PW-1:WIDTH] != '0);
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = (bus.k == '0) ? DONE : MUL;
        end
      end
      MUL: begin
        if (bit_idx == IDX_W'(WIDTH - 1)) begin
          last_bit = 1'b1;
          if (pass_cnt == EXP_W'(1)) begin
            last_pass = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, handshake flags and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.overflow  <= 1'b0;
      b_reg         <= '0;
      acc           <= '0;
      prod          <= '0;
      bit_idx       <= '0;
      pass_cnt      <= '0;
      ovf           <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.in_ready  <= (state_nxt == IDLE);
      bus.out_valid <= (state_nxt == DONE);
      if (accept) begin
        b_reg    <= bus.b;
        acc      <= bus.a;
        ovf      <= 1'b0;
        pass_cnt <= bus.k;
        bit_idx  <= '0;
        prod     <= '0;
        if (bus.k == '0) begin
          bus.out      <= bus.a;
          bus.overflow <= 1'b0;
        end
      end else if (state == MUL) begin
        if (last_bit) begin
          acc      <= psum[WIDTH-1:0];
          ovf      <= ovf_nxt;
          prod     <= '0;
          bit_idx  <= '0;
          pass_cnt <= pass_cnt - 1'b1;
          if (last_pass) begin
            bus.out      <= psum[WIDTH-1:0];
            bus.overflow <= ovf_nxt;
          end
        end else begin
          prod    <= psum;
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_pow_seq.sv
// Scoreboard bench for mult_pow_seq: 8-bit and 16-bit instances, expected results
// queued at acceptance from a plain power model and compared when results appear.
module tb_mult_pow_seq;

  typedef struct {
    longint unsigned res;
    bit              ovf;
    int              lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q8[$];
  exp_t q16[$];
  int   t8, t16;
  bit   seen8, seen16, hs8, hs16;

  mult_pow_seq_if #(.WIDTH(8),  .EXP_W(4)) if8 ();
  mult_pow_seq_if #(.WIDTH(16), .EXP_W(4)) if16 ();

  mult_pow_seq #(.WIDTH(8),  .EXP_W(4)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  mult_pow_seq #(.WIDTH(16), .EXP_W(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input longint unsigned a, input longint unsigned b,
                                 input int k);
    exp_t e;
    longint unsigned mask, acc, full;
    mask  = (64'd1 << w) - 1;
    acc   = a & mask;
    e.ovf = 1'b0;
    for (int i = 0; i < k; i++) begin
      full = acc * (b & mask);
      if ((full >> w) != 0) e.ovf = 1'b1;
      acc = full & mask;
    end
    e.res = acc;
    e.lat = 1 + k * w;
    return e;
  endfunction

  // Scoreboard monitors: push at acceptance, pop on the first cycle of out_valid
  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q16.delete();
      seen8 = 0; seen16 = 0; hs8 = 0; hs16 = 0;
    end else begin
      if (hs8) begin
        chk("in_ready_after_hs8", if8.in_ready, 1);
        chk("out_valid_after_hs8", if8.out_valid, 0);
        hs8 = 0;
      end
      if (if8.in_valid && if8.in_ready) begin
        q8.push_back(model(8, if8.a, if8.b, int'(if8.k)));
        t8 = cyc;
      end
      if (if8.out_valid && !seen8) begin
        seen8 = 1;
        if (q8.size() == 0) chk("spurious_out8", 1, 0);
        else begin
          exp_t e;
          e = q8.pop_front();
          chk("out8", if8.out, e.res);
          chk("ovf8", if8.overflow, e.ovf);
          chk("lat8", cyc - t8, e.lat);
        end
      end
      if (if8.out_valid && if8.out_ready) begin
        seen8 = 0;
        hs8   = 1;
      end

      if (hs16) begin
        chk("in_ready_after_hs16", if16.in_ready, 1);
        hs16 = 0;
      end
      if (if16.in_valid && if16.in_ready) begin
        q16.push_back(model(16, if16.a, if16.b, int'(if16.k)));
        t16 = cyc;
      end
      if (if16.out_valid && !seen16) begin
        seen16 = 1;
        if (q16.size() == 0) chk("spurious_out16", 1, 0);
        else begin
          exp_t e;
          e = q16.pop_front();
          chk("out16", if16.out, e.res);
          chk("ovf16", if16.overflow, e.ovf);
          chk("lat16", cyc - t16, e.lat);
        end
      end
      if (if16.out_valid && if16.out_ready) begin
        seen16 = 0;
        hs16   = 1;
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] k);
    int n;
    @(posedge clk); #1;
    if8.a = a; if8.b = b; if8.k = k; if8.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!if8.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout8", 0, 1);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.k = 4'($urandom);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] k);
    int n;
    @(posedge clk); #1;
    if16.a = a; if16.b = b; if16.k = k; if16.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!if16.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout16", 0, 1);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    if16.a = 16'($urandom); if16.b = 16'($urandom); if16.k = 4'($urandom);
  endtask

  task automatic wait_all(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(q8.size() == 0 && q16.size() == 0 && !seen8 && !seen16 && !hs8 && !hs16 &&
             if8.in_ready && if16.in_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("result_timeout", 0, 1);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0;
    if8.in_valid = 0;  if8.a = 0;  if8.b = 0;  if8.k = 0;  if8.out_ready = 1;
    if16.in_valid = 0; if16.a = 0; if16.b = 0; if16.k = 0; if16.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", if8.in_ready, 1);
    chk("rst_out_valid", if8.out_valid, 0);
    chk("rst_out", if8.out, 0);
    chk("rst_overflow", if8.overflow, 0);
    rst_n = 1'b1;

    send8(8'd2, 8'd3, 4'd3);            wait_all(200);
    send8(8'hA5, 8'h07, 4'd0);          wait_all(50);
    send8(8'hFF, 8'hFF, 4'd2);          wait_all(200);

    // Backpressure: result held for five cycles, handshake in the sixth
    if8.out_ready = 1'b0;
    send8(8'd2, 8'd3, 4'd1);
    n = 0;
    while (!if8.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("bp_valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out", if8.out, 6);
      chk("bp_valid", if8.out_valid, 1);
      chk("bp_in_ready", if8.in_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    if8.out_ready = 1'b1;
    wait_all(50);

    // Reset in cycle 10 of a k=3 request
    send8(8'd2, 8'd3, 4'd3);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", if8.out_valid, 0);
    chk("midrst_out", if8.out, 0);
    chk("midrst_overflow", if8.overflow, 0);
    chk("midrst_in_ready", if8.in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send8(8'd4, 8'd2, 4'd2);            wait_all(200);

    // Random requests, including maximum exponent
    send8(8'($urandom), 8'($urandom), 4'd15); wait_all(300);
    for (int i = 0; i < 6; i++) begin
      send8(8'($urandom), 8'($urandom), 4'($urandom));
      wait_all(300);
    end

    send16(16'd3, 16'd10, 4'd4);        wait_all(300);
    send16(16'd1, 16'd2, 4'd15);        wait_all(400);
    send16(16'($urandom), 16'($urandom), 4'($urandom_range(1, 15))); wait_all(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_pow_seq.md
Name: mult_pow_seq

Overview:
- Parametrised, iterative successor to the fixed 8x8 combinational multiplier.
- Computes out = a * b^k (mod 2^WIDTH) using a shift-add datapath that processes one multiplier bit per cycle.
- Has valid/ready handshakes on input and output, plus a sticky overflow flag.
- Sits in the arithmetic library as an area-cheap alternative where multi-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- EXP_W, 4, width of the exponent input k.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request carries valid a, b, k.
- in_ready  output  1  block can accept a request; high only in IDLE.
- a  input  WIDTH  multiplicand (unsigned).
- b  input  WIDTH  base (unsigned).
- k  input  EXP_W  exponent (unsigned).
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  a * b^k, truncated to WIDTH bits.
- overflow  output  1  set if any intermediate full product exceeded WIDTH bits.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; in_ready = 1; out_valid = 0; out = 0; overflow = 0.
  - All counters and the accumulator are cleared.
  - Reset asserted mid-operation aborts the operation immediately; no result is produced.
- States: IDLE, MUL, DONE.
- IDLE:
  - Acceptance occurs when in_valid && in_ready; this is cycle 0.
  - On acceptance: a, b, k are captured into registers; acc <= a; ovf <= 0.
  - If k == 0: go to DONE. Otherwise go to MUL with pass_cnt = k, bit_idx = 0, prod = 0.
  - Input changes after acceptance are ignored.
- MUL (one bit of b per cycle):
  - Each cycle: if b_reg[bit_idx] is set, prod <= prod + (acc << bit_idx); prod is 2*WIDTH bits wide.
  - On the cycle with bit_idx == WIDTH-1, the final partial sum p (including this cycle's term) is committed:
    - acc <= p[WIDTH-1:0]
    - ovf <= ovf | (p[2*WIDTH-1:WIDTH] != 0)
    - prod <= 0; bit_idx <= 0; pass_cnt <= pass_cnt - 1.
    - If pass_cnt == 1, go to DONE.
  - Each pass takes exactly WIDTH cycles regardless of b, including b == 0 (no early termination).
- Latency: out_valid is first high in cycle 1 + k*WIDTH, counted from the acceptance cycle (cycle 1 for k == 0).
- DONE:
  - out = acc and overflow = ovf; both are held stable while out_valid is high.
  - When out_valid && out_ready: go to IDLE; out_valid is low and in_ready is high from the next cycle.
  - There is no same-cycle accept while in DONE; maximum throughput is one request per (2 + k*WIDTH) cycles.
  - out and overflow keep their last values in IDLE until the next result is produced.
- in_ready is a registered-state decode (state == IDLE); there is no combinational path from out_ready to in_ready.
- All arithmetic is unsigned. The truncation after each pass makes the result equal (a * b^k) mod 2^WIDTH.
- k at its maximum value (2^EXP_W - 1) must complete correctly; pass_cnt must not wrap.

Test Plan:
- WIDTH=8: a=2, b=3, k=3, out_ready=1 -> out_valid first high in cycle 25, out=54, overflow=0; in_ready high again in cycle 26.
- k=0, a=0xA5, b=0x07 -> out_valid in cycle 1, out=0xA5, overflow=0.
- a=0xFF, b=0xFF, k=2 -> first pass 65025 -> acc=0x01 with overflow set; final out=0xFF, overflow=1, out_valid in cycle 17.
- Backpressure: a=2, b=3, k=1 with out_ready held low for 5 cycles after out_valid -> out=6 stable, out_valid high, in_ready low throughout; handshake on cycle 6 -> IDLE on the following cycle.
- Reset mid-operation: a=2, b=3, k=3, pull rst_n low at cycle 10 -> out_valid=0, out=0, overflow=0, in_ready=1 immediately; a new request a=4, b=2, k=2 then yields out=16 in cycle 17.
- WIDTH=16, EXP_W=4: a=3, b=10, k=4 -> out=30000, overflow=0, out_valid in cycle 65; then a=1, b=2, k=15 -> out=32768, overflow=0.
